// File: rtl/apb_nslave_pkg.sv
// Shared types and helpers for the N-slave APB master bridge.
package apb_nslave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   // Width of the slave-index field taken from the top address bits.
   function automatic int SELW(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the top address bits to a one-hot slave select; flags indices with no slave.
module apb_addr_decode
   import apb_nslave_pkg::*;
#(
   parameter int AW = 32,
   parameter int NS = 2
) (
   input  logic [AW-1:0] addr_i,
   output logic [NS-1:0] sel_o,
   output logic          err_o
);

   localparam int SW = SELW(NS);

   logic [SW-1:0] idx;
   logic          unused_lsb;

   assign idx        = addr_i[AW-1 -: SW];
   assign unused_lsb = ^addr_i[AW-SW-1:0];

   always_comb begin
      sel_o = '0;
      err_o = 1'b0;
      if (int'(idx) >= NS) err_o = 1'b1;
      else                 sel_o[idx] = 1'b1;
   end

endmodule

// File: rtl/apb_nslave_master.sv
// APB master bridge: request port to APB cycles toward NS slaves, with wait
// states, slave errors, decode errors, access timeout and back-to-back transfers.
//
// state  | meaning
// IDLE   | ready for a request; emits decode-error responses
// SETUP  | psel asserted, penable low, request latched onto the bus
// ACCESS | penable high, waiting for pready or timeout
module apb_nslave_master
   import apb_nslave_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int NS      = 2,
   parameter int TIMEOUT = 256
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             transfer,
   input  logic             read_write,
   input  logic [AW-1:0]    apb_write_paddr,
   input  logic [AW-1:0]    apb_read_paddr,
   input  logic [DW-1:0]    apb_write_data,
   input  logic [DW/8-1:0]  apb_write_strb,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic             rsp_err,
   output logic [DW-1:0]    apb_read_data_out,
   output logic [NS-1:0]    psel,
   output logic             penable,
   output logic             pwrite,
   output logic [AW-1:0]    paddr,
   output logic [DW-1:0]    pwdata,
   output logic [DW/8-1:0]  pstrb,
   input  logic [NS*DW-1:0] prdata,
   input  logic [NS-1:0]    pready,
   input  logic [NS-1:0]    pslverr
);

   typedef struct packed {
      logic            write;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW/8-1:0] strb;
   } req_t;

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_e          state_q;
   req_t            req_d, req_q;
   logic [NS-1:0]   sel_q;
   logic            penable_q;
   logic            rsp_valid_q, rsp_err_q;
   logic            err_pend_q;
   logic [DW-1:0]   rdata_q;
   logic [CW-1:0]   wcnt_q;

   logic [NS-1:0]   dec_sel;
   logic            dec_err;
   logic            pready_s, pslverr_s, done, timeout_hit, accept;
   logic [DW-1:0]   prdata_s;

   always_comb begin
      req_d.write = read_write;
      req_d.addr  = read_write ? apb_write_paddr : apb_read_paddr;
      req_d.data  = apb_write_data;
      req_d.strb  = read_write ? apb_write_strb : '0;
   end

   // Decode the incoming address so the accept edge already knows the target.
   apb_addr_decode #(.AW(AW), .NS(NS)) u_dec (
      .addr_i (req_d.addr),
      .sel_o  (dec_sel),
      .err_o  (dec_err)
   );

   always_comb begin
      prdata_s = '0;
      for (int i = 0; i < NS; i++)
         if (sel_q[i]) prdata_s = prdata_s | prdata[i*DW +: DW];
   end

   assign pready_s    = |(pready & sel_q);
   assign pslverr_s   = |(pslverr & sel_q);
   assign done        = (state_q == ST_ACCESS) && pready_s;
   assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready_s
                        && (wcnt_q == TO_LAST);
   assign req_ready   = presetn && ((state_q == ST_IDLE) || done);
   assign accept      = transfer && req_ready;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         sel_q       <= '0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         err_pend_q  <= 1'b0;
         rdata_q     <= '0;
         wcnt_q      <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               // A decode error accepted on a completion cycle is answered here.
               if (err_pend_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
               end
               err_pend_q <= 1'b0;
               if (accept) begin
                  if (dec_err) begin
                     if (err_pend_q) err_pend_q <= 1'b1;
                     else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                     end
                  end else begin
                     req_q   <= req_d;
                     sel_q   <= dec_sel;
                     state_q <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               wcnt_q    <= '0;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready_s) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= pslverr_s;
                  if (!req_q.write && !pslverr_s) rdata_q <= prdata_s;
                  penable_q <= 1'b0;
                  sel_q     <= '0;
                  state_q   <= ST_IDLE;
                  if (accept) begin
                     if (dec_err) err_pend_q <= 1'b1;
                     else begin
                        req_q   <= req_d;
                        sel_q   <= dec_sel;
                        state_q <= ST_SETUP;
                     end
                  end
               end else if (timeout_hit) begin
                  penable_q   <= 1'b0;
                  sel_q       <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= ST_IDLE;
               end else if (TIMEOUT != 0) begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign psel              = sel_q;
   assign penable           = penable_q;
   assign pwrite            = req_q.write;
   assign paddr             = req_q.addr;
   assign pwdata            = req_q.data;
   assign pstrb             = req_q.strb;
   assign rsp_valid         = rsp_valid_q;
   assign rsp_err           = rsp_err_q;
   assign apb_read_data_out = rdata_q;

endmodule

// File: tb/tb_apb_nslave_master.sv
// Directed bench for apb_nslave_master (NS=3, TIMEOUT=4) with response and APB scoreboards.
module tb_apb_nslave_master;

   logic        pclk, presetn, transfer, read_write;
   logic [31:0] apb_write_paddr, apb_read_paddr, apb_write_data;
   logic [3:0]  apb_write_strb;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] apb_read_data_out;
   logic [2:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [95:0] prdata;
   logic [2:0]  pready, pslverr;

   apb_nslave_master #(.AW(32), .DW(32), .NS(3), .TIMEOUT(4)) dut (
      .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
      .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
      .apb_write_data(apb_write_data), .apb_write_strb(apb_write_strb),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
      .apb_read_data_out(apb_read_data_out), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
   endtask

   // ---------------- slave model ----------------
   logic [31:0] mem [logic [31:0]];
   int          waits = 0;
   logic [2:0]  stuck = 3'b000;
   bit          err_mode = 0, force_rd = 0;
   logic [31:0] force_val = 32'h0;
   int          acc = 0;

   always @(negedge pclk) begin
      logic [31:0] v;
      pready  = 3'b111;
      pslverr = 3'b111;
      prdata  = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
      if (presetn && $onehot(psel)) begin
         for (int i = 0; i < 3; i++) if (psel[i]) begin
            pready[i]  = 1'b0;
            pslverr[i] = 1'b0;
            v = mem.exists(paddr) ? mem[paddr] : 32'h0;
            prdata[i*32 +: 32] = force_rd ? force_val : v;
            if (penable) begin
               acc++;
               if (acc > waits && !stuck[i]) begin
                  pready[i]  = 1'b1;
                  pslverr[i] = err_mode;
                  if (pwrite && !err_mode) begin
                     for (int b = 0; b < 4; b++) if (pstrb[b]) v[b*8 +: 8] = pwdata[b*8 +: 8];
                     mem[paddr] = v;
                  end
               end
            end else acc = 0;
         end
      end else acc = 0;
   end

   // ---------------- scoreboards ----------------
   typedef struct { logic err; logic [31:0] data; int at; } rsp_t;
   typedef struct { logic [2:0] sel; logic [31:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; } apb_t;
   rsp_t rsp_q[$];
   apb_t apb_q[$];
   logic [31:0] held = 32'h0;

   always @(negedge pclk) begin
      rsp_t r;
      if (presetn && rsp_valid) begin
         if (rsp_q.size() == 0) fail_now("unexpected rsp_valid");
         else begin
            r = rsp_q.pop_front();
            chk("rsp cycle", cyc, r.at);
            chk("rsp_err", rsp_err, r.err);
            chk("read data", apb_read_data_out, r.data);
         end
      end
   end

   apb_t cur;
   bit   have_cur = 0;
   always @(negedge pclk) begin
      if (!presetn) have_cur = 0;
      else if (psel != 3'b000 && !penable) begin
         if (apb_q.size() == 0) fail_now("unexpected psel");
         else begin
            cur = apb_q.pop_front();
            have_cur = 1;
            chk("setup psel", psel, cur.sel);
            chk("setup paddr", paddr, cur.addr);
            chk("setup pwrite", pwrite, cur.wr);
            chk("setup pstrb", pstrb, cur.strb);
            if (cur.wr) chk("setup pwdata", pwdata, cur.wdata);
         end
      end else if (psel != 3'b000) begin
         if (!have_cur) fail_now("access without setup");
         else begin
            chk("access psel", psel, cur.sel);
            chk("access paddr stable", paddr, cur.addr);
         end
      end else if (penable) fail_now("penable without psel");
   end

   // ---------------- driver ----------------
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int lat, input logic exp_err,
                        input logic [31:0] rd_val, input bit b2b, input bit push, output int obs);
      apb_t a;
      rsp_t r;
      logic [1:0] ix;
      @(negedge pclk);
      read_write      = wr;
      apb_write_paddr = wr ? addr : addr ^ 32'h4000_0004;
      apb_read_paddr  = wr ? addr ^ 32'h4000_0004 : addr;
      apb_write_data  = wr ? wdata : 32'h5A5A_5A5A;
      apb_write_strb  = wr ? strb : 4'hF;
      transfer        = 1'b1;
      obs = -1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (req_ready) begin obs = cyc; break; end
         @(negedge pclk);
      end
      if (obs < 0) begin
         fail_now("req_ready wait");
         transfer = 1'b0;
         return;
      end
      ix = addr[31:30];
      if (ix != 2'd3) begin
         a.sel = 3'b001 << ix; a.addr = addr; a.wr = wr; a.wdata = wdata;
         a.strb = wr ? strb : 4'h0;
         apb_q.push_back(a);
      end
      if (push) begin
         if (!wr && !exp_err) held = rd_val;
         r.err = exp_err; r.data = held; r.at = obs + lat;
         rsp_q.push_back(r);
      end
      @(posedge pclk);
      if (!b2b) begin
         @(negedge pclk);
         transfer = 1'b0;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (rsp_q.size() != 0 && k < 60) begin @(negedge pclk); k++; end
      if (rsp_q.size() != 0) fail_now("response drain");
      @(negedge pclk);
      #2;
   endtask

   task automatic chk_rst(input string t);
      chk({t, " psel"}, psel, 0);
      chk({t, " penable/pwrite/pstrb"}, {penable, pwrite, pstrb}, 0);
      chk({t, " paddr"}, paddr, 0);
      chk({t, " pwdata"}, pwdata, 0);
      chk({t, " rsp_valid/rsp_err"}, {rsp_valid, rsp_err}, 0);
      chk({t, " read data"}, apb_read_data_out, 0);
      chk({t, " req_ready"}, req_ready, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int o1, o2, o3, ot, on;
      transfer = 0; read_write = 0; apb_write_paddr = 0; apb_read_paddr = 0;
      apb_write_data = 0; apb_write_strb = 0;
      presetn = 1'b1;
      #1 presetn = 1'b0;
      #2 chk_rst("reset");
      repeat (3) @(negedge pclk);
      presetn = 1'b1;
      #1 chk("req_ready after release", req_ready, 1);

      // zero-wait write/read on slave 2, then a partial-strobe update
      issue(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 0, 1, o1);
      issue(0, 32'h8000_0010, 0, 0, 3, 0, 32'hDEAD_BEEF, 0, 1, o1);
      issue(1, 32'h8000_0010, 32'h1122_3344, 4'b0011, 3, 0, 0, 0, 1, o1);
      issue(0, 32'h8000_0010, 0, 0, 3, 0, 32'hDEAD_3344, 0, 1, o1);
      drain();

      // three wait states
      waits = 3;
      issue(1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 6, 0, 0, 0, 1, o1);
      drain();
      waits = 0;

      // back-to-back
      issue(1, 32'h4000_0020, 32'h0BAD_CAFE, 4'hF, 3, 0, 0, 1, 1, o1);
      issue(0, 32'h4000_0020, 0, 0, 3, 0, 32'h0BAD_CAFE, 1, 1, o2);
      issue(0, 32'h0000_0040, 0, 0, 3, 0, 32'hCAFE_F00D, 0, 1, o3);
      chk("b2b second accept", o2, o1 + 2);
      chk("b2b third accept", o3, o2 + 2);
      drain();

      // slave error on read: data output holds
      err_mode = 1; force_rd = 1; force_val = 32'h0000_1234;
      issue(0, 32'h4000_0020, 0, 0, 3, 1, 0, 0, 1, o1);
      drain();
      err_mode = 0; force_rd = 0;

      // decode error (index 3)
      issue(0, 32'hC000_0000, 0, 0, 1, 1, 0, 0, 1, o1);
      issue(1, 32'hC000_0008, 32'h7777_7777, 4'hF, 1, 1, 0, 0, 1, o1);
      drain();

      // timeout on stuck slave 2, new request accepted right after
      stuck = 3'b100;
      issue(0, 32'h8000_0010, 0, 0, 6, 1, 0, 1, 1, ot);
      issue(0, 32'h0000_0040, 0, 0, 3, 0, 32'hCAFE_F00D, 0, 1, on);
      chk("accept after timeout", on, ot + 6);
      drain();

      // reset in the middle of ACCESS drops the transfer silently
      stuck = 3'b001;
      issue(0, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 0, o1);
      @(negedge pclk);
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1 chk_rst("mid-access reset");
      held = 32'h0;
      stuck = 3'b000;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      #1 chk("req_ready after mid reset", req_ready, 1);
      repeat (8) @(negedge pclk);
      issue(0, 32'h8000_0010, 0, 0, 3, 0, 32'hDEAD_3344, 0, 1, o1);
      drain();

      chk("rsp queue empty", rsp_q.size(), 0);
      chk("apb queue empty", apb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
